// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring (T1..T6), opcode decode
// into the 12-bit control word, halt latch and run/single-step advance logic.
module controller_sequencer (
   input  logic       CLK,
   input  logic       CLR_bar,
   input  logic [3:0] instr_in,
   input  logic       RUN,
   input  logic       STEP,
   output logic       Cp,
   output logic       Ep,
   output logic       Lm_bar,
   output logic       CE_bar,
   output logic       Li_bar,
   output logic       Ei_bar,
   output logic       La_bar,
   output logic       Lb_bar,
   output logic       Lo_bar,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic [5:0] t_state,
   output logic       HLT
);

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   logic [5:0] t_state_reg;
   logic [5:0] t_state_next;
   logic [5:0] ring_rot;
   logic       hlt_reg;
   logic       hlt_next;
   logic       step_prev_reg;
   logic       state_legal;
   logic       adv;

   // Rotate-left of the ring: each bit takes its predecessor, T6 wraps to T1.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_ring
         if (gi == 0) begin : g_wrap
            assign ring_rot[gi] = t_state_reg[5];
         end else begin : g_shift
            assign ring_rot[gi] = t_state_reg[gi-1];
         end
      end
   endgenerate

   // Exactly one bit set; anything else is an upset and falls back to T1.
   assign state_legal = (t_state_reg != 6'd0) &&
                        ((t_state_reg & (t_state_reg - 6'd1)) == 6'd0);

   // Free-run advances every cycle; single-step advances on a STEP rising edge.
   assign adv = RUN | (STEP & ~step_prev_reg);

   // Next ring state and halt latch.
   always_comb begin
      t_state_next = t_state_reg;
      if (hlt_reg) begin
         t_state_next = T5;
      end else if (!state_legal) begin
         t_state_next = T1;
      end else if (adv) begin
         t_state_next = ring_rot;
      end
      hlt_next = hlt_reg | (adv & (t_state_reg == T4) & (instr_in == OP_HLT));
   end

   // State registers with asynchronous clear; reset aborts any instruction.
   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) begin
         t_state_reg   <= T1;
         hlt_reg       <= 1'b0;
         step_prev_reg <= 1'b0;
      end else begin
         t_state_reg   <= t_state_next;
         hlt_reg       <= hlt_next;
         step_prev_reg <= STEP;
      end
   end

   // Control word decode; instr_in is only consulted in T4..T6.
   always_comb begin
      Cp     = 1'b0;
      Ep     = 1'b0;
      Lm_bar = 1'b1;
      CE_bar = 1'b1;
      Li_bar = 1'b1;
      Ei_bar = 1'b1;
      La_bar = 1'b1;
      Lb_bar = 1'b1;
      Lo_bar = 1'b1;
      Ea     = 1'b0;
      Su     = 1'b0;
      Eu     = 1'b0;
      if (!hlt_reg) begin
         case (t_state_reg)
            T1: begin
               Ep     = 1'b1;
               Lm_bar = 1'b0;
            end
            T2: Cp = 1'b1;
            T3: begin
               CE_bar = 1'b0;
               Li_bar = 1'b0;
            end
            T4: begin
               case (instr_in)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     Lm_bar = 1'b0;
                     Ei_bar = 1'b0;
                  end
                  OP_OUT: begin
                     Ea     = 1'b1;
                     Lo_bar = 1'b0;
                  end
                  default: ;
               endcase
            end
            T5: begin
               case (instr_in)
                  OP_LDA: begin
                     CE_bar = 1'b0;
                     La_bar = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     CE_bar = 1'b0;
                     Lb_bar = 1'b0;
                  end
                  default: ;
               endcase
            end
            T6: begin
               if (instr_in == OP_ADD || instr_in == OP_SUB) begin
                  La_bar = 1'b0;
                  Eu     = 1'b1;
                  Su     = (instr_in == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign t_state = t_state_reg;
   assign HLT     = hlt_reg;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: stimulus pushes hand-computed
// expectations, a monitor pops and compares at each sample point.
module tb_controller_sequencer;

   // Control word packing: {Cp,Ep,Lm,CE,Li,Ei,La,Lb,Lo,Ea,Su,Eu}
   localparam logic [11:0] W_IDLE  = 12'b0011_1111_1000;
   localparam logic [11:0] W_T1    = 12'b0101_1111_1000;
   localparam logic [11:0] W_T2    = 12'b1011_1111_1000;
   localparam logic [11:0] W_T3    = 12'b0010_0111_1000;
   localparam logic [11:0] W_T4M   = 12'b0001_1011_1000;
   localparam logic [11:0] W_LDA5  = 12'b0010_1101_1000;
   localparam logic [11:0] W_ADD5  = 12'b0010_1110_1000;
   localparam logic [11:0] W_ADD6  = 12'b0011_1101_1001;
   localparam logic [11:0] W_SUB6  = 12'b0011_1101_1011;
   localparam logic [11:0] W_OUT4  = 12'b0011_1111_0100;

   localparam logic [5:0] S1 = 6'b000001;
   localparam logic [5:0] S2 = 6'b000010;
   localparam logic [5:0] S3 = 6'b000100;
   localparam logic [5:0] S4 = 6'b001000;
   localparam logic [5:0] S5 = 6'b010000;
   localparam logic [5:0] S6 = 6'b100000;

   typedef struct packed {
      logic [5:0]  st;
      logic [11:0] w;
      logic        h;
   } exp_t;

   logic       CLK;
   logic       CLR_bar;
   logic [3:0] instr_in;
   logic       RUN;
   logic       STEP;
   logic       Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar;
   logic       Ea, Su, Eu;
   logic [5:0] t_state;
   logic       HLT;
   logic [11:0] act_w;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   event sample_ev;

   controller_sequencer dut (
      .CLK(CLK), .CLR_bar(CLR_bar), .instr_in(instr_in), .RUN(RUN), .STEP(STEP),
      .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar), .Li_bar(Li_bar),
      .Ei_bar(Ei_bar), .La_bar(La_bar), .Lb_bar(Lb_bar), .Lo_bar(Lo_bar),
      .Ea(Ea), .Su(Su), .Eu(Eu), .t_state(t_state), .HLT(HLT)
   );

   assign act_w = {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar, Ea, Su, Eu};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Sample point one time unit after each rising edge.
   always @(posedge CLK) begin
      #1;
      ->sample_ev;
   end

   // Monitor: pop one expectation per sample point and compare.
   initial begin : monitor
      exp_t e;
      forever begin
         @(sample_ev);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (t_state !== e.st || act_w !== e.w || HLT !== e.h) begin
               miscompares++;
               $display("FAIL vec%0d: got t_state=%b word=%b HLT=%b, expected t_state=%b word=%b HLT=%b",
                        vectors, t_state, act_w, HLT, e.st, e.w, e.h);
            end else begin
               $display("vec%0d: t_state=%b word=%b HLT=%b ok", vectors, t_state, act_w, HLT);
            end
         end
      end
   end

   // Push an expectation for the state after the next rising edge, then
   // return at the following falling edge.
   task automatic tick(input logic [5:0] st, input logic [11:0] w, input logic h);
      exp_t e;
      e.st = st;
      e.w  = w;
      e.h  = h;
      exp_q.push_back(e);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Assert reset mid-cycle and check the result before any clock edge.
   task automatic async_reset_check();
      exp_t e;
      CLR_bar = 1'b0;
      #1;
      e.st = S1;
      e.w  = W_T1;
      e.h  = 1'b0;
      exp_q.push_back(e);
      ->sample_ev;
   endtask

   // One full free-running instruction starting from T1; fetch uses a
   // garbage opcode so any early decode shows up.
   task automatic instr(input logic [3:0] op, input logic [11:0] w4,
                        input logic [11:0] w5, input logic [11:0] w6);
      instr_in = 4'hF;
      tick(S2, W_T2, 1'b0);
      tick(S3, W_T3, 1'b0);
      instr_in = op;
      tick(S4, w4, 1'b0);
      tick(S5, w5, 1'b0);
      tick(S6, w6, 1'b0);
      instr_in = 4'hF;
      tick(S1, W_T1, 1'b0);
   endtask

   initial begin : stimulus
      CLR_bar  = 1'b0;
      RUN      = 1'b1;
      STEP     = 1'b0;
      instr_in = 4'hF;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) tick(S1, W_T1, 1'b0);
      CLR_bar = 1'b1;

      // Walk after release with a NOP opcode (0111)
      instr(4'b0111, W_IDLE, W_IDLE, W_IDLE);
      instr(4'b0000, W_T4M, W_LDA5, W_IDLE);
      instr(4'b0001, W_T4M, W_ADD5, W_ADD6);
      instr(4'b0010, W_T4M, W_ADD5, W_SUB6);
      instr(4'b1110, W_OUT4, W_IDLE, W_IDLE);

      // Single-step: STEP held high five cycles gives one advance
      RUN = 1'b0;
      instr_in = 4'b0111;
      STEP = 1'b1;
      tick(S2, W_T2, 1'b0);
      for (int i = 0; i < 4; i++) tick(S2, W_T2, 1'b0);
      STEP = 1'b0; tick(S2, W_T2, 1'b0);
      // Three single-cycle pulses give three advances
      STEP = 1'b1; tick(S3, W_T3, 1'b0);
      STEP = 1'b0; tick(S3, W_T3, 1'b0);
      STEP = 1'b1; tick(S4, W_IDLE, 1'b0);
      STEP = 1'b0; tick(S4, W_IDLE, 1'b0);
      STEP = 1'b1; tick(S5, W_IDLE, 1'b0);
      STEP = 1'b0; tick(S5, W_IDLE, 1'b0);
      // Back to free-run, effective on the same edge
      RUN = 1'b1;
      tick(S6, W_IDLE, 1'b0);
      tick(S1, W_T1, 1'b0);

      // OUT interrupted by reset during T5
      instr_in = 4'hF;
      tick(S2, W_T2, 1'b0);
      tick(S3, W_T3, 1'b0);
      instr_in = 4'b1110;
      tick(S4, W_OUT4, 1'b0);
      tick(S5, W_IDLE, 1'b0);
      async_reset_check();
      tick(S1, W_T1, 1'b0);
      CLR_bar = 1'b1;

      // HLT: idle T4, halt on the edge ending T4, stuck at T5 for 20 cycles
      instr_in = 4'hF;
      tick(S2, W_T2, 1'b0);
      tick(S3, W_T3, 1'b0);
      tick(S4, W_IDLE, 1'b0);
      tick(S5, W_IDLE, 1'b1);
      for (int i = 0; i < 20; i++) begin
         RUN  = (i < 10);
         STEP = i[0];
         tick(S5, W_IDLE, 1'b1);
      end
      RUN  = 1'b1;
      STEP = 1'b0;
      async_reset_check();
      tick(S1, W_T1, 1'b0);
      CLR_bar = 1'b1;
      tick(S2, W_T2, 1'b0);

      // Drain with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge CLK);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

Control unit of the SAP-1 CPU, directly downstream of the instruction register. Consumes the 4-bit opcode (`instr_in`) and runs a six-state ring counter (T1–T6). From the state and opcode it decodes the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers. It also provides the halt latch and a run/single-step mode for bring-up on the board.

## Interface
- Parameters: none.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `CLR_bar`  in  1  asynchronous, active-low reset.
- `instr_in`  in  4  opcode from the instruction register, valid from T4 through T6.
- `RUN`  in  1  1 = free-running; 0 = single-step.
- `STEP`  in  1  single-step request, level input, synchronous to `CLK`; a 0→1 transition advances one T-state.
- `Cp`, `Ep`  out  1 each  PC increment, PC enable (active-high).
- `Lm_bar`, `CE_bar`, `Li_bar`, `Ei_bar`, `La_bar`, `Lb_bar`, `Lo_bar`  out  1 each  active-low loads/enables for MAR, RAM, IR, IR address field, A, B and OUT.
- `Ea`, `Su`, `Eu`  out  1 each  accumulator enable, ALU subtract, ALU enable (active-high).
- `t_state`  out  6  one-hot ring state; bit 0 = T1.
- `HLT`  out  1  halted flag (registered).

## Operation
- Opcodes:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
  - All others decode as NOP.
- Idle control word:
  - Active-high signals = 0.
  - Active-low signals = 1.
  - Every signal not listed for a state below is idle.
- Fetch cycle:
  - T1: `Ep`=1, `Lm_bar`=0.
  - T2: `Cp`=1.
  - T3: `CE_bar`=0, `Li_bar`=0.
- LDA:
  - T4: `Lm_bar`=0, `Ei_bar`=0.
  - T5: `CE_bar`=0, `La_bar`=0.
  - T6: idle.
- ADD:
  - T4: as LDA.
  - T5: `CE_bar`=0, `Lb_bar`=0.
  - T6: `La_bar`=0, `Eu`=1.
- SUB: same as ADD, plus `Su`=1 in T6 only.
- OUT: T4 `Ea`=1, `Lo_bar`=0; T5 and T6 idle.
- HLT and NOP: T4–T6 idle.
- Control outputs are combinational from the registered state and `instr_in`. There is no latch on the control word.
- Advance condition `adv`:
  - `RUN`=1: every cycle.
  - `RUN`=0: only in a cycle where `STEP`=1 and `STEP` was 0 in the previous cycle (one-cycle edge detect register).
- Ring sequence on `adv`: T1→T2→…→T6→T1.
- Halt:
  - When `adv` and state = T4 and `instr_in`=1111, set `HLT`.
  - While `HLT`=1 the ring holds at T5, every control output is idle, and `adv` is ignored.
  - Only reset clears `HLT`.
- Reset, asynchronous on `CLR_bar`=0:
  - `t_state`=000001 (T1).
  - `HLT`=0.
  - Step edge register = 0.
  - Outputs therefore show the T1 word: `Ep`=1, `Lm_bar`=0, all others idle.
  - Reset asserted mid-instruction aborts it immediately; there is no partial-state recovery.

## Timing
- One T-state per `adv` cycle. An instruction takes exactly 6 advances, including fetch.
- The IR samples `Li_bar`=0 at the rising edge that ends T3. `instr_in` is therefore stable for the whole of T4–T6; decode must not look at `instr_in` in T1–T3.
- `HLT` rises at the edge that ends T4 of a HLT instruction. T4 of HLT shows the idle word.
- Single-step:
  - The first `STEP` rise after reset or after a `RUN` change is honoured if the prior sampled `STEP` was 0.
  - Holding `STEP` high gives exactly one advance.
- `RUN` may toggle at any cycle; it takes effect on the same edge.
- `t_state` must never be all-zero or multi-hot. Any illegal encoding recovers to T1 on the next edge.

## Test plan
- Reset with `RUN`=1, hold `CLR_bar`=0 for 3 cycles, then release:
  - `t_state`=000001 during reset, and `Ep`=1, `Lm_bar`=0.
  - After release, `t_state` walks 000010, 000100, … 100000, then 000001.
- LDA (`instr_in`=0000 from T4): T4 shows `Lm_bar`=0, `Ei_bar`=0; T5 shows `CE_bar`=0, `La_bar`=0; T6 is idle.
- SUB (`instr_in`=0010): T5 shows `Lb_bar`=0; T6 shows `La_bar`=0, `Eu`=1, `Su`=1. The same run with 0001 gives `Su`=0 in T6.
- HLT (`instr_in`=1111):
  - `HLT`=1 on the edge after T4, and `t_state` sticks at 010000 with the idle word for 20 cycles.
  - Pulling `CLR_bar` low returns T1 and `HLT`=0.
- `RUN`=0 with `STEP` held high for 5 cycles: exactly one advance. Three separate 1-cycle `STEP` pulses give exactly three advances.
- Opcode 0111 (NOP) and OUT (1110):
  - NOP: T4–T6 idle.
  - OUT: T4 shows `Ea`=1, `Lo_bar`=0.
  - A reset asserted during T5 returns `t_state` to 000001 asynchronously.
